// File: rtl/counter.sv
// Up-counter over 0..count with synchronous clear/enable and a terminal-count flag.
// Build option: COUNTER_SATURATE_EN makes the counter stick at count instead of wrapping.
module counter #(
    parameter logic [31:0] count = 32'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] cnt,
    output logic        tc
);

    logic [31:0] nxt;

    // >= rather than == so an out-of-range value recovers to 0 on the next enabled edge
    always_comb begin
        nxt = cnt;
        if (clr) begin
            nxt = '0;
        end else if (en) begin
`ifdef COUNTER_SATURATE_EN
            if (cnt == count) begin
                nxt = count;
            end else if (cnt > count) begin
                nxt = '0;
            end else begin
                nxt = cnt + 32'd1;
            end
`else
            if (cnt >= count) begin
                nxt = '0;
            end else begin
                nxt = cnt + 32'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

    assign tc = (cnt == count);

endmodule

// File: tb/tb_counter.sv
// Table-driven scoreboard bench for counter: one instance at count=15, one at count=0.
// Honours COUNTER_SATURATE_EN when computing expected values for long enabled runs.
module tb_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] cnt;
    logic        tc;
    logic [31:0] cntz;
    logic        tcz;

    typedef struct {
        logic        r;
        logic        c;
        logic        e;
        logic [31:0] exp;
        logic        exptc;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic        tc;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    counter #(.count(32'd15)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .cnt(cnt), .tc(tc)
    );

    counter #(.count(32'd0)) dutz (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .cnt(cntz), .tc(tcz)
    );

    // Value after the k-th enabled edge counted from 0 (count = 15)
    function automatic logic [31:0] expRun(int k);
`ifdef COUNTER_SATURATE_EN
        return (k > 15) ? 32'd15 : 32'(k);
`else
        return 32'(k % 16);
`endif
    endfunction

    function automatic void addVec(logic r, logic c, logic e, logic [31:0] x);
        vec_t v;
        v.r     = r;
        v.c     = c;
        v.e     = e;
        v.exp   = x;
        v.exptc = (x == 32'd15);
        vecs.push_back(v);
    endfunction

    function automatic void addRun(int n, int start);
        for (int k = 1; k <= n; k++) begin
            addVec(1'b1, 1'b0, 1'b1, expRun(start + k));
        end
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t x;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            x = sb.pop_front();
            compare({x.name, " cnt"},  cnt,  x.cnt);
            compare({x.name, " tc"},   {31'd0, tc},  {31'd0, x.tc});
            compare({x.name, " cntz"}, cntz, 32'd0);
            compare({x.name, " tcz"},  {31'd0, tcz}, 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic e,
                                 input logic [31:0] x, input logic xt,
                                 input string name, input bit glitch);
        exp_t s;
        @(negedge clk);
        rst = r;
        clr = c;
        en  = e;
        s.cnt  = x;
        s.tc   = xt;
        s.name = name;
        sb.push_back(s);
        if (glitch) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        addVec(1'b0, 1'b0, 1'b1, 32'd0);
        addRun(17, 0);
        addVec(1'b1, 1'b1, 1'b0, 32'd0);
        addRun(10, 0);
        addVec(1'b1, 1'b1, 1'b1, 32'd0);
        addRun(5, 0);
        for (int i = 0; i < 5; i++) addVec(1'b1, 1'b0, 1'b0, 32'd5);
        addRun(7, 5);
        addVec(1'b0, 1'b0, 1'b1, 32'd0);
        addRun(1, 0);
        addVec(1'b0, 1'b1, 1'b1, 32'd0);
        addRun(15, 0);
        addVec(1'b1, 1'b1, 1'b1, 32'd0);
        addRun(20, 0);
        addVec(1'b1, 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].c, vecs[i].e, vecs[i].exp, vecs[i].exptc,
                          $sformatf("vec%0d", i), 1'b0);
        end

        // rst pulses between edges must not disturb counting
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'(k), 1'b0, $sformatf("glitch%0d", k), 1'b1);
        end

        // unknown clr/en while reset is asserted still clears
        applyStimulus(1'b0, 1'bx, 1'bx, 32'd0, 1'b0, "xreset", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, "holdzero", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd1, 1'b0, "resume", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Parametric 32-bit up-counter with synchronous clear and count-enable.
- Counts 0..count inclusive, then wraps to 0.
- Used as a generic cycle/event counter and timebase in datapath and control blocks.
- Exposes the current value and a terminal-count flag.

Parameters:
- count, 32'd15, terminal value (inclusive upper bound); legal range 0..2^32-1.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  reset, synchronous, active-low (sampled on rising clk edge).
- clr  input  1  synchronous clear, active-high.
- en  input  1  count enable, active-high.
- cnt  output  32  current count value, registered.
- tc  output  1  terminal count flag; combinational, high when cnt == count.

Behaviour:
- All state changes on rising edge of clk only; no asynchronous paths.
- Priority per edge: rst low > clr high > en high > hold.
- rst == 0 at edge: cnt <= 0. This is the reset value of cnt; tc = (count == 0) during reset.
- clr == 1 (rst high): cnt <= 0, regardless of en.
- en == 1 (rst high, clr low):
  - cnt == count: cnt <= 0 (wrap).
  - Otherwise: cnt <= cnt + 1.
- en == 0 (rst high, clr low): cnt holds.
- Latency: cnt reflects an action one edge after the inputs are sampled. tc follows cnt in the same cycle.
- Wrap period with en held high: count+1 cycles (16 for default).
- count == 0: cnt stays 0; tc constantly 1.
- count == 32'hFFFFFFFF: natural 32-bit wrap to 0; no overflow flag.
- cnt > count is unreachable in normal operation. If ever present (e.g. X-recovery), next enabled edge loads 0. Comparison uses >=, not ==.
- Reset or clr mid-count: takes effect at the next edge; counting resumes from 0 on the following enabled edge.
- clr and en both high: clear wins; cnt = 0 after the edge, not 1.
- X on en or clr while rst is low: cnt still resets to 0.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: on reaching count, cnt holds at count while en stays high instead of wrapping. Only clr or rst return it to 0. tc stays high while saturated.
- Undefined (default): wrap-around behaviour as specified above.
- Port list is identical in both builds.

Test Plan:
1. count=15; rst low 1 cycle, then high; en=1 -> cnt = 0,1,2,…,15,0,1 on successive edges; tc high only in the cycle cnt=15.
2. Mid-count (cnt=10): clr=1 for one edge with en=1 -> cnt=0 after that edge; then 1,2,… on subsequent edges.
3. At cnt=5: en=0 for 5 edges -> cnt holds at 5; en=1 -> cnt=6 on next edge.
4. At cnt=12: rst=0 for one edge (en=1, clr=0) -> cnt=0; rst=1 -> cnt=1 on next edge. Also confirm a glitch on rst between edges has no effect.
5. Simultaneous rst=0 and clr=1 and en=1 -> cnt=0. Separately, clr=1 and en=1 at cnt=15 -> cnt=0 and tc deasserts.
6. COUNTER_SATURATE_EN defined, count=15, en=1 for 20 edges -> cnt reaches 15 and stays; tc=1; clr=1 -> cnt=0. Rerun scenario 1 with count=0 -> cnt constantly 0, tc=1.
